// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the MIPS run/step sequencer: FSM states, halt causes
// and the program-slot shift used to form the instruction-memory base.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE       = 2'd0,
        HC_HALT_INSTR = 2'd1,
        HC_BREAKPOINT = 2'd2,
        HC_USER_STOP  = 2'd3
    } halt_cause_e;

    // Each resident program occupies a 512-word slot of instruction memory.
    localparam int unsigned PROG_SHIFT = 9;

endpackage

// File: rtl/cpu_run_ctrl_btn_edge.sv
// Button conditioner: two-flop synchroniser plus a history flop, producing a
// single-cycle pulse for each rising edge of the raw input.
module btn_edge
    import cpu_run_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~hist_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the single-cycle MIPS core: program load with core
// reset hold, commit gating (run/step/breakpoint/halt/stop) and commit count.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [2:0]       prog_sel,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             single,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  cpu_pc,
    input  logic             cpu_halt,
    output logic             cpu_ce,
    output logic             cpu_rst_n,
    output logic [11:0]      prog_base,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

    logic start_p;
    logic step_p;
    logic stop_p;

    btn_edge u_start (.clk(clk), .rst_n(RST), .btn(start), .pulse(start_p));
    btn_edge u_step  (.clk(clk), .rst_n(RST), .btn(step),  .pulse(step_p));
    btn_edge u_stop  (.clk(clk), .rst_n(RST), .btn(stop),  .pulse(stop_p));

    state_e            state_q, state_d;
    halt_cause_e       cause_q, cause_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [11:0]       base_q, base_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              skip_q, skip_d;

    logic        bp_hit;
    logic        stop_cond;
    logic        enter_load;
    halt_cause_e hit_cause;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cause_q  <= HC_NONE;
            hold_q   <= '0;
            base_q   <= '0;
            cycles_q <= '0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            hold_q   <= hold_d;
            base_q   <= base_d;
            cycles_q <= cycles_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        hold_d     = hold_q;
        base_d     = base_q;
        skip_d     = skip_q;
        cycles_d   = cycles_q;
        cpu_ce     = 1'b0;
        enter_load = 1'b0;

        // bp_skip lets a resumed breakpoint PC commit once without re-trapping.
        bp_hit    = bp_en & (cpu_pc == bp_addr) & ~skip_q;
        stop_cond = stop_p | bp_hit | cpu_halt;
        if (stop_p)      hit_cause = HC_USER_STOP;
        else if (bp_hit) hit_cause = HC_BREAKPOINT;
        else             hit_cause = HC_HALT_INSTR;

        unique case (state_q)
            ST_IDLE: begin
                if (start_p) enter_load = 1'b1;
            end
            ST_LOAD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) state_d = single ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                if (stop_cond) begin
                    state_d = ST_HALT;
                    cause_d = hit_cause;
                end else begin
                    cpu_ce = 1'b1;
                    if (single) state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (stop_p) begin
                    state_d = ST_HALT;
                    cause_d = HC_USER_STOP;
                end else if (step_p && stop_cond) begin
                    state_d = ST_HALT;
                    cause_d = hit_cause;
                end else begin
                    cpu_ce = step_p;
                    if (!single) state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (start_p) begin
                    if (cause_q == HC_HALT_INSTR) begin
                        enter_load = 1'b1;
                    end else begin
                        state_d = single ? ST_STEP : ST_RUN;
                        cause_d = HC_NONE;
                        skip_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_load) begin
            state_d  = ST_LOAD;
            base_d   = {prog_sel, {PROG_SHIFT{1'b0}}};
            cause_d  = HC_NONE;
            hold_d   = HOLD_W'(RST_HOLD);
            cycles_d = '0;
        end else if (cpu_ce && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end

        if (cpu_ce) skip_d = 1'b0;
    end

    assign cpu_rst_n  = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_HALT);
    assign prog_base  = base_q;
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: load table plus hand-written run/step,
// breakpoint, halt, stop and reset sequences, with a behavioural core PC.
module tb_cpu_run_ctrl;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] PC_BASE = 32'h0040_0000;

    logic             clk = 1'b0;
    logic             RST = 1'b0;
    logic [2:0]       prog_sel = '0;
    logic             start = 1'b0, step = 1'b0, stop = 1'b0, single = 1'b0;
    logic             bp_en = 1'b0, cpu_halt = 1'b0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic [PC_W-1:0]  cpu_pc;
    logic             cpu_ce, cpu_rst_n;
    logic [11:0]      prog_base;
    logic [2:0]       state;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycles;

    cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(4)) dut (
        .clk(clk), .RST(RST), .prog_sel(prog_sel), .start(start), .step(step),
        .stop(stop), .single(single), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_pc(cpu_pc), .cpu_halt(cpu_halt), .cpu_ce(cpu_ce),
        .cpu_rst_n(cpu_rst_n), .prog_base(prog_base), .state(state),
        .halt_cause(halt_cause), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Behavioural core: PC advances by one word on each committed cycle.
    always @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) cpu_pc <= PC_BASE;
        else if (cpu_ce) cpu_pc <= cpu_pc + 32'd4;
    end

    int ce_total = 0;
    always @(negedge clk) if (cpu_ce === 1'b1) ce_total++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        int st, ce, rstn, cause, cyc, base;   // -1 = don't care
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [2:0] sel;
        logic       single;
        int         base;
        int         st;
    } vec_t;
    vec_t vt[8];

    task automatic expect_o(input string n, input int st, input int ce, input int rstn,
                            input int cause, input int cyc, input int base);
        exp_t e;
        e.name = n; e.st = st; e.ce = ce; e.rstn = rstn;
        e.cause = cause; e.cyc = cyc; e.base = base;
        exp_q.push_back(e);
    endtask

    task automatic look();
        exp_t e;
        bit ok;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ok = 1'b1;
            if (e.st    >= 0 && int'(state)      != e.st)    ok = 1'b0;
            if (e.ce    >= 0 && int'(cpu_ce)     != e.ce)    ok = 1'b0;
            if (e.rstn  >= 0 && int'(cpu_rst_n)  != e.rstn)  ok = 1'b0;
            if (e.cause >= 0 && int'(halt_cause) != e.cause) ok = 1'b0;
            if (e.cyc   >= 0 && int'(cycles)     != e.cyc)   ok = 1'b0;
            if (e.base  >= 0 && int'(prog_base)  != e.base)  ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s: got st=%0d ce=%0d rstn=%0d cause=%0d cyc=%0d base=%0h, want st=%0d ce=%0d rstn=%0d cause=%0d cyc=%0d base=%0h",
                         e.name, state, cpu_ce, cpu_rst_n, halt_cause, cycles, prog_base,
                         e.st, e.ce, e.rstn, e.cause, e.cyc, e.base);
            end
        end
    endtask

    task automatic chk_int(input string n, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        RST = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; cpu_halt = 1'b0;
        tick(3);
        RST = 1'b1;
        tick(1);
    endtask

    task automatic press_start(); start = 1'b1; tick(1); start = 1'b0; tick(2); endtask
    task automatic press_step();  step  = 1'b1; tick(1); step  = 1'b0; tick(2); endtask

    // Press start from IDLE and wait out LOAD; returns LOAD length and
    // whether the core reset stayed low throughout.
    task automatic do_load(output int n_load, output bit rst_low);
        n_load = 0;
        rst_low = 1'b1;
        press_start();
        while (state == 3'd1 && n_load < 20) begin
            if (cpu_rst_n !== 1'b0) rst_low = 1'b0;
            n_load++;
            tick(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  nl;
    bit  rl;
    int  snap;

    initial begin
        vt[0] = '{3'd0, 1'b0, 'h000, 2};
        vt[1] = '{3'd1, 1'b1, 'h200, 3};
        vt[2] = '{3'd2, 1'b0, 'h400, 2};
        vt[3] = '{3'd3, 1'b1, 'h600, 3};
        vt[4] = '{3'd4, 1'b0, 'h800, 2};
        vt[5] = '{3'd5, 1'b1, 'hA00, 3};
        vt[6] = '{3'd6, 1'b0, 'hC00, 2};
        vt[7] = '{3'd7, 1'b1, 'hE00, 3};

        // Reset state
        reset_dut();
        expect_o("reset", 0, 0, 0, 0, 0, 'h000);
        look();
        tick(1);
        expect_o("idle_ignore_btn", 0, 0, 0, 0, 0, 'h000);
        step = 1'b1; stop = 1'b1; tick(4); step = 1'b0; stop = 1'b0;
        look();

        // Load table: base latch, LOAD length, run vs step entry
        for (int i = 0; i < 8; i++) begin
            reset_dut();
            prog_sel = vt[i].sel;
            single   = vt[i].single;
            press_start();
            prog_sel = ~vt[i].sel;
            expect_o($sformatf("load_enter[%0d]", i), 1, 0, 0, 0, 0, vt[i].base);
            look();
            nl = 1;
            tick(1);
            while (state == 3'd1 && nl < 20) begin nl++; tick(1); end
            chk_int($sformatf("load_len[%0d]", i), nl, 4);
            expect_o($sformatf("load_exit[%0d]", i), vt[i].st, (vt[i].st == 2) ? 1 : 0,
                     1, 0, 0, vt[i].base);
            look();
        end

        // Free run from program 3 and run<->step switching
        reset_dut();
        single = 1'b0; prog_sel = 3'd3;
        do_load(nl, rl);
        chk_int("t2_load_len", nl, 4);
        chk_int("t2_rst_low", int'(rl), 1);
        expect_o("t2_run", 2, 1, 1, 0, 0, 'h600);
        look();
        tick(10);
        expect_o("t2_cycles10", 2, 1, 1, 0, 10, 'h600);
        look();
        single = 1'b1;
        expect_o("t2_run_to_step_commit", 2, 1, 1, 0, 10, -1);
        look();
        tick(1);
        expect_o("t2_in_step", 3, 0, 1, 0, 11, -1);
        look();
        single = 1'b0;
        tick(1);
        expect_o("t2_back_run", 2, 1, 1, 0, 11, -1);
        look();

        // Breakpoint, resume past it, counter saturation
        reset_dut();
        single = 1'b0; prog_sel = 3'd1; bp_en = 1'b1; bp_addr = 32'h0040_0010;
        do_load(nl, rl);
        tick(4);
        chk_int("t3_pc_at_bp", int'(cpu_pc), 32'h0040_0010);
        expect_o("t3_bp_no_commit", 2, 0, 1, 0, 4, -1);
        look();
        tick(1);
        expect_o("t3_bp_halt", 4, 0, 1, 2, 4, -1);
        look();
        press_start();
        expect_o("t3_resume", 2, 1, 1, 0, 4, 'h200);
        look();
        tick(1);
        expect_o("t3_bp_commit_once", 2, 1, 1, 0, 5, -1);
        look();
        tick(10);
        expect_o("t3_no_retrigger", 2, 1, 1, 0, 15, -1);
        look();
        tick(5);
        expect_o("t3_saturate", 2, 1, 1, 0, 15, -1);
        look();
        bp_en = 1'b0;

        // Single-step: exactly one commit per step press
        reset_dut();
        single = 1'b1; prog_sel = 3'd2;
        do_load(nl, rl);
        expect_o("t4_step_entry", 3, 0, 1, 0, 0, 'h400);
        look();
        snap = ce_total;
        repeat (3) begin
            press_step();
            tick(7);
        end
        chk_int("t4_ce_pulses", ce_total - snap, 3);
        chk_int("t4_pc", int'(cpu_pc), 32'h0040_000C);
        expect_o("t4_after_steps", 3, 0, 1, 0, 3, -1);
        look();

        // Halt instruction then reload with a new program
        reset_dut();
        single = 1'b0; prog_sel = 3'd2;
        do_load(nl, rl);
        tick(3);
        prog_sel = 3'd6;
        cpu_halt = 1'b1;
        expect_o("t5_halt_no_commit", 2, 0, 1, 0, 3, 'h400);
        look();
        tick(1);
        cpu_halt = 1'b0;
        expect_o("t5_halted", 4, 0, 1, 1, 3, 'h400);
        look();
        prog_sel = 3'd5;
        press_start();
        expect_o("t5_reload", 1, 0, 0, 0, 0, 'hA00);
        look();

        // Stop pulse coincident with a breakpoint hit
        reset_dut();
        single = 1'b0; prog_sel = 3'd0; bp_en = 1'b1; bp_addr = 32'h0040_0008;
        do_load(nl, rl);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        chk_int("t6_pc_at_bp", int'(cpu_pc), 32'h0040_0008);
        expect_o("t6_stop_no_commit", 2, 0, 1, 0, 2, -1);
        look();
        tick(1);
        expect_o("t6_stop_wins", 4, 0, 1, 3, 2, -1);
        look();
        bp_en = 1'b0;

        // Asynchronous reset mid-run
        reset_dut();
        single = 1'b0; prog_sel = 3'd7;
        do_load(nl, rl);
        tick(3);
        RST = 1'b0;
        expect_o("t6_async_rst", 0, 0, 0, 0, 0, 'h000);
        look();
        RST = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step sequencer for the single-cycle MIPS core on the FPGA board top level.
- Selects which of 8 resident programs to load and holds the core in reset while loading.
- Gates the core's commit via a clock enable: free-run, single-step, breakpoint, halt-instruction stop or user stop.
- Exposes state, halt cause and a committed-instruction counter for the LED/seven-segment display logic.

Parameters:
PC_W, 32, width of the core PC and breakpoint address
CNT_W, 32, width of committed-instruction counter (saturating)
RST_HOLD, 4, cycles cpu_rst_n is held low on program load (>=1)

Ports:
clk  in  1  system clock
RST  in  1  asynchronous active-low reset
prog_sel  in  3  program index, latched on load only
start  in  1  raw button: load / resume (rising edge)
step  in  1  raw button: single-step (rising edge)
stop  in  1  raw button: user stop (rising edge)
single  in  1  level switch: 1 = step mode after load/resume
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
cpu_pc  in  PC_W  current core PC
cpu_halt  in  1  core decodes a halt (syscall) at cpu_pc this cycle
cpu_ce  out  1  core commit enable (PC/regfile/memory update)
cpu_rst_n  out  1  core reset, active-low
prog_base  out  12  instruction-memory word base = {prog_sel,9'b0}
state  out  3  FSM state code
halt_cause  out  2  0 none, 1 halt instr, 2 breakpoint, 3 user stop
cycles  out  CNT_W  committed instructions since last load

Behaviour:
- Reset (RST=0, async): state=IDLE, cpu_ce=0, cpu_rst_n=0, prog_base=0, halt_cause=0, cycles=0, bp_skip=0, hold counter=0.
- Button conditioning per input: 2-FF synchroniser plus 1 history FF. Pulse = sync2 & ~hist, one cycle wide. A level held high gives exactly one pulse. The FSM acts at the 3rd rising clk edge after the input rises.
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- bp_hit = bp_en & (cpu_pc==bp_addr) & ~bp_skip.
- Stop priority in RUN/STEP: stop pulse > bp_hit > cpu_halt. Any of these forces cpu_ce=0 in that cycle. The instruction at cpu_pc is not committed.
- cpu_ce is combinational:
  - RUN: 1 unless a stop condition holds.
  - STEP: 1 only in the cycle a step pulse arrives and no stop condition holds.
  - All other states: 0.
- cycles: +1 on every cycle with cpu_ce=1; saturates at all-ones; cleared on entry to LOAD.
- bp_skip: set on resume from HALT; cleared after the first committed instruction.
- IDLE: start pulse -> LOAD. Latch prog_base={prog_sel,9'b0}, clear cycles and halt_cause, hold=RST_HOLD. step/stop ignored.
- LOAD: cpu_rst_n=0, hold decrements each cycle. At hold==1 -> RUN if single=0, else STEP. cpu_rst_n=1 from the first RUN/STEP cycle. Buttons ignored.
- RUN:
  - Stop condition -> HALT with its cause.
  - single=1 (no stop condition) -> STEP at the next edge; the current cycle still commits.
- STEP:
  - Step pulse with a stop condition -> HALT with its cause, no commit.
  - single=0 -> RUN.
  - stop pulse -> HALT, cause 3.
- HALT: cpu_ce=0, cpu_rst_n=1.
  - start pulse, cause 1 -> LOAD with the current prog_sel (full reload).
  - start pulse, cause 2/3 -> RUN/STEP per single; halt_cause=0; bp_skip=1.
- prog_sel changes outside IDLE/HALT(cause 1) have no effect.
- RST asserted mid-operation returns immediately to reset values; the core is held in reset (cpu_rst_n=0).

Decomposition:
- Shared package: state encodings, halt-cause codes, PROG_SHIFT=9 constant.
- One sub-module btn_edge (synchroniser + rising-edge pulse), instantiated for start, step and stop.

Test Plan:
1. Hold RST=0 for 3 cycles, then release -> state=0, cpu_rst_n=0, cpu_ce=0, cycles=0, prog_base=0x000.
2. prog_sel=3, single=0, pulse start -> prog_base=0x600, state=1 for exactly 4 cycles with cpu_rst_n=0; then state=2, cpu_ce=1; 10 cycles later cycles=10.
3. RUN, bp_en=1, bp_addr=0x00400010; cpu_pc steps by 4 from 0x00400000:
   - at pc 0x00400010: cpu_ce=0, state=4, halt_cause=2, cycles=4.
   - pulse start: pc 0x00400010 commits once (cycles=5), run continues with no re-trigger.
4. single=1, load, then three step pulses spaced 10 cycles apart -> cpu_ce high for exactly 3 single cycles, cycles=3, state stays 3.
5. RUN, assert cpu_halt -> state=4, halt_cause=1, no commit. Set prog_sel=5, pulse start -> LOAD, prog_base=0xA00, cycles=0.
6. stop pulse in the same cycle as bp_hit -> halt_cause=3. Separately, RST=0 mid-RUN -> same cycle: state=0, cpu_ce=0, cpu_rst_n=0.
